// File: rtl/ddr_burst_copy_engine_pkg.sv
// Shared types and helpers for the DDR burst copy engine.
// Holds the FSM state encoding, the IPIF length width and the burst length/stride helpers.
package ddr_copy_pkg;

  localparam int IPIF_LEN_W = 20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_REQ   = 3'd1,
    RD_DATA  = 3'd2,
    WR_REQ   = 3'd3,
    WR_DATA  = 3'd4,
    WR_CMPLT = 3'd5,
    DONE     = 3'd6
  } copy_state_e;

  function automatic logic [IPIF_LEN_W-1:0] burst_len_bytes(input int beats, input int data_w);
    return IPIF_LEN_W'(beats * (data_w / 8));
  endfunction

  // A stride of zero means bursts are packed back to back.
  function automatic logic [31:0] burst_stride(input int stride, input int beats, input int data_w);
    return (stride == 0) ? 32'(beats * (data_w / 8)) : 32'(stride);
  endfunction

endpackage

// File: rtl/ddr_burst_copy_engine_if.sv
// AXI master burst IPIF signal bundle between the copy engine (master) and the IPIF (slave).
interface ddr_burst_copy_engine_if #(parameter int DATA_W = 64);
  import ddr_copy_pkg::*;

  logic                  ip2bus_mstrd_req;
  logic                  ip2bus_mstwr_req;
  logic [31:0]           ip2bus_mst_addr;
  logic [IPIF_LEN_W-1:0] ip2bus_mst_length;
  logic [DATA_W/8-1:0]   ip2bus_mst_be;
  logic                  ip2bus_mst_type;
  logic                  ip2bus_mst_lock;
  logic                  ip2bus_mst_reset;
  logic                  bus2ip_mst_cmdack;
  logic                  bus2ip_mst_cmplt;
  logic                  bus2ip_mst_error;
  logic [DATA_W-1:0]     bus2ip_mstrd_d;
  logic                  bus2ip_mstrd_src_rdy_n;
  logic                  ip2bus_mstrd_dst_rdy_n;
  logic                  ip2bus_mstrd_dst_dsc_n;
  logic [DATA_W-1:0]     ip2bus_mstwr_d;
  logic                  ip2bus_mstwr_src_rdy_n;
  logic                  ip2bus_mstwr_sof_n;
  logic                  ip2bus_mstwr_eof_n;
  logic                  ip2bus_mstwr_src_dsc_n;
  logic [DATA_W/8-1:0]   ip2bus_mstwr_rem;
  logic                  bus2ip_mstwr_dst_rdy_n;

  modport master (
    output ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_length,
           ip2bus_mst_be, ip2bus_mst_type, ip2bus_mst_lock, ip2bus_mst_reset,
           ip2bus_mstrd_dst_rdy_n, ip2bus_mstrd_dst_dsc_n, ip2bus_mstwr_d,
           ip2bus_mstwr_src_rdy_n, ip2bus_mstwr_sof_n, ip2bus_mstwr_eof_n,
           ip2bus_mstwr_src_dsc_n, ip2bus_mstwr_rem,
    input  bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error, bus2ip_mstrd_d,
           bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
  );

  modport slave (
    input  ip2bus_mstrd_req, ip2bus_mstwr_req, ip2bus_mst_addr, ip2bus_mst_length,
           ip2bus_mst_be, ip2bus_mst_type, ip2bus_mst_lock, ip2bus_mst_reset,
           ip2bus_mstrd_dst_rdy_n, ip2bus_mstrd_dst_dsc_n, ip2bus_mstwr_d,
           ip2bus_mstwr_src_rdy_n, ip2bus_mstwr_sof_n, ip2bus_mstwr_eof_n,
           ip2bus_mstwr_src_dsc_n, ip2bus_mstwr_rem,
    output bus2ip_mst_cmdack, bus2ip_mst_cmplt, bus2ip_mst_error, bus2ip_mstrd_d,
           bus2ip_mstrd_src_rdy_n, bus2ip_mstwr_dst_rdy_n
  );

endinterface

// File: rtl/ddr_burst_copy_engine_buffer.sv
// copy_burst_buffer: one-burst FIFO between the read and write phases.
// Head entry is prefetched into an output register so dout is valid whenever empty is low.
module copy_burst_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [AW:0]       level_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] dout_r;
  logic              push_s, pop_s, load_s;

  assign full   = (level_r + {{AW{1'b0}}, out_valid_r}) == (AW+1)'(DEPTH);
  assign empty  = ~out_valid_r;
  assign dout   = dout_r;
  assign push_s = push & ~full;
  assign pop_s  = pop & out_valid_r;
  assign load_s = (level_r != {(AW+1){1'b0}}) & (~out_valid_r | pop_s);

  // Storage array, no reset needed
  always_ff @(posedge clock) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

  // Pointers, occupancy and prefetch register
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      level_r     <= {(AW+1){1'b0}};
      out_valid_r <= 1'b0;
      dout_r      <= {DATA_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      level_r <= level_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, load_s};
      if (load_s) begin
        dout_r      <= mem_r[rd_ptr_r];
        rd_ptr_r    <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        out_valid_r <= 1'b1;
      end else if (pop_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ddr_burst_copy_engine.sv
// DDR block-copy engine: NUM bursts read into a local buffer, then written back, one burst at a time.
// Optional cycle counter enabled by defining DDR_COPY_PERF_CNT_EN.
module ddr_burst_copy_engine
  import ddr_copy_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int BURST_BEATS = 16,
  parameter int CNT_W       = 16,
  parameter int ADDR_STRIDE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      rd_base,
  input  logic [31:0]      wr_base,
  input  logic [CNT_W-1:0] num_bursts,
  output logic             busy,
  output logic             op_done,
  output logic             op_error,
  output logic [31:0]      cycle_count,
  ddr_burst_copy_engine_if.master bus
);
  localparam int          BW      = $clog2(BURST_BEATS);
  localparam logic [31:0] STRIDE  = burst_stride(ADDR_STRIDE, BURST_BEATS, DATA_W);
  localparam logic [BW:0] BEATS_C = (BW+1)'(BURST_BEATS);
  localparam logic [BW-1:0] LAST_C = BW'(BURST_BEATS - 1);

  copy_state_e state_r, next_s;
  logic [CNT_W-1:0] num_r, k_r, k_nxt_s;
  logic [31:0] rd_addr_r, wr_addr_r, rd_addr_nxt_s, wr_addr_nxt_s, mst_addr_r, mst_addr_s;
  logic [BW:0] rd_cnt_r;
  logic [BW-1:0] wr_beat_r;
  logic rd_ovf_r, wcmplt_r, werr_r;
  logic busy_r, op_done_r, op_error_r, rd_req_r, wr_req_r;
  logic busy_s, op_done_s, op_error_s, rd_req_s, wr_req_s;
  logic accept_s, rd_beat_s, rd_bad_s, wr_valid_s, wr_beat_s, wr_done_s, wr_err_s, err_set_s;
  logic buf_full_s, buf_empty_s;
  logic [DATA_W-1:0] buf_dout_s;

  assign accept_s   = (state_r == IDLE) & start;
  assign rd_beat_s  = (state_r == RD_DATA) & ~bus.bus2ip_mstrd_src_rdy_n;
  // A short or long read burst is treated like a bus error.
  assign rd_bad_s   = bus.bus2ip_mst_error | rd_ovf_r | (rd_beat_s & (rd_cnt_r == BEATS_C))
                    | ((rd_cnt_r + {{BW{1'b0}}, rd_beat_s}) != BEATS_C);
  assign wr_valid_s = (state_r == WR_DATA) & ~buf_empty_s;
  assign wr_beat_s  = wr_valid_s & ~bus.bus2ip_mstwr_dst_rdy_n;
  // Write completion may arrive early (with cmdack or during data); it is remembered until WR_CMPLT.
  assign wr_done_s  = (state_r == WR_CMPLT) & (bus.bus2ip_mst_cmplt | wcmplt_r);
  assign wr_err_s   = (bus.bus2ip_mst_cmplt & bus.bus2ip_mst_error) | werr_r;
  assign k_nxt_s    = k_r + {{(CNT_W-1){1'b0}}, 1'b1};
  assign err_set_s  = ((state_r == RD_REQ) & bus.bus2ip_mst_cmdack & bus.bus2ip_mst_cmplt)
                    | ((state_r == RD_DATA) & bus.bus2ip_mst_cmplt & rd_bad_s)
                    | (wr_done_s & wr_err_s);
  assign rd_addr_nxt_s = accept_s ? rd_base : (wr_done_s ? rd_addr_r + STRIDE : rd_addr_r);
  assign wr_addr_nxt_s = accept_s ? wr_base : (wr_done_s ? wr_addr_r + STRIDE : wr_addr_r);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= next_s;
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:     if (start) next_s = (num_bursts == {CNT_W{1'b0}}) ? DONE : RD_REQ;
                else next_s = IDLE;
      RD_REQ:   if (bus.bus2ip_mst_cmdack) next_s = bus.bus2ip_mst_cmplt ? DONE : RD_DATA;
                else next_s = RD_REQ;
      RD_DATA:  if (bus.bus2ip_mst_cmplt) next_s = rd_bad_s ? DONE : WR_REQ;
                else next_s = RD_DATA;
      WR_REQ:   if (bus.bus2ip_mst_cmdack) next_s = WR_DATA;
                else next_s = WR_REQ;
      WR_DATA:  if (wr_beat_s && (wr_beat_r == LAST_C)) next_s = WR_CMPLT;
                else next_s = WR_DATA;
      WR_CMPLT: if (wr_done_s) next_s = (wr_err_s || (k_nxt_s == num_r)) ? DONE : RD_REQ;
                else next_s = WR_CMPLT;
      DONE:     next_s = IDLE;
      default:  next_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered control outputs
  always_comb begin
    busy_s     = busy_r;
    op_done_s  = 1'b0;
    op_error_s = op_error_r;
    rd_req_s   = 1'b0;
    wr_req_s   = 1'b0;
    mst_addr_s = mst_addr_r;
    case (next_s)
      RD_REQ:  begin rd_req_s = 1'b1; mst_addr_s = rd_addr_nxt_s; end
      WR_REQ:  begin wr_req_s = 1'b1; mst_addr_s = wr_addr_nxt_s; end
      default: begin rd_req_s = 1'b0; wr_req_s = 1'b0; end
    endcase
    if (accept_s) begin
      busy_s     = 1'b1;
      op_error_s = 1'b0;
    end else if (state_r == DONE) begin
      busy_s    = 1'b0;
      op_done_s = 1'b1;
    end else if (err_set_s) begin
      op_error_s = 1'b1;
    end else begin
      busy_s = busy_r;
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_r <= 1'b0; op_done_r <= 1'b0; op_error_r <= 1'b0;
      rd_req_r <= 1'b0; wr_req_r <= 1'b0; mst_addr_r <= 32'd0;
    end else begin
      busy_r <= busy_s; op_done_r <= op_done_s; op_error_r <= op_error_s;
      rd_req_r <= rd_req_s; wr_req_r <= wr_req_s; mst_addr_r <= mst_addr_s;
    end
  end

  // Burst index, addresses and per-burst beat bookkeeping
  always_ff @(posedge clock) begin
    if (!reset) begin
      num_r <= {CNT_W{1'b0}}; k_r <= {CNT_W{1'b0}};
      rd_addr_r <= 32'd0; wr_addr_r <= 32'd0;
      rd_cnt_r <= {(BW+1){1'b0}}; rd_ovf_r <= 1'b0; wr_beat_r <= {BW{1'b0}};
      wcmplt_r <= 1'b0; werr_r <= 1'b0;
    end else begin
      if (accept_s) num_r <= num_bursts;
      if (accept_s)       k_r <= {CNT_W{1'b0}};
      else if (wr_done_s) k_r <= k_nxt_s;
      rd_addr_r <= rd_addr_nxt_s;
      wr_addr_r <= wr_addr_nxt_s;
      if (state_r != RD_DATA) begin
        rd_cnt_r <= {(BW+1){1'b0}};
        rd_ovf_r <= 1'b0;
      end else if (rd_beat_s) begin
        if (rd_cnt_r == BEATS_C) rd_ovf_r <= 1'b1;
        else                     rd_cnt_r <= rd_cnt_r + {{BW{1'b0}}, 1'b1};
      end
      if (state_r != WR_DATA) wr_beat_r <= {BW{1'b0}};
      else if (wr_beat_s)     wr_beat_r <= wr_beat_r + {{(BW-1){1'b0}}, 1'b1};
      if ((state_r == WR_REQ) || (state_r == WR_DATA)) begin
        wcmplt_r <= wcmplt_r | bus.bus2ip_mst_cmplt;
        werr_r   <= werr_r | (bus.bus2ip_mst_cmplt & bus.bus2ip_mst_error);
      end else begin
        wcmplt_r <= 1'b0;
        werr_r   <= 1'b0;
      end
    end
  end

  copy_burst_buffer #(.DATA_W(DATA_W), .DEPTH(BURST_BEATS)) u_buffer (
    .clock (clock),
    .reset (reset),
    .clear (state_r == DONE),
    .push  (rd_beat_s),
    .din   (bus.bus2ip_mstrd_d),
    .pop   (wr_beat_s),
    .full  (buf_full_s),
    .empty (buf_empty_s),
    .dout  (buf_dout_s)
  );

`ifdef DDR_COPY_PERF_CNT_EN
  logic [31:0] cycle_r;
  // Busy-cycle counter, frozen once the operation ends
  always_ff @(posedge clock) begin
    if (!reset)        cycle_r <= 32'd0;
    else if (accept_s) cycle_r <= 32'd0;
    else if (busy_r)   cycle_r <= cycle_r + 32'd1;
    else               cycle_r <= cycle_r;
  end
  assign cycle_count = cycle_r;
`else
  assign cycle_count = 32'd0;
`endif

  assign busy     = busy_r;
  assign op_done  = op_done_r;
  assign op_error = op_error_r;

  assign bus.ip2bus_mstrd_req       = rd_req_r;
  assign bus.ip2bus_mstwr_req       = wr_req_r;
  assign bus.ip2bus_mst_addr        = mst_addr_r;
  assign bus.ip2bus_mst_length      = burst_len_bytes(BURST_BEATS, DATA_W);
  assign bus.ip2bus_mst_be          = {(DATA_W/8){1'b1}};
  assign bus.ip2bus_mst_type        = 1'b1;
  assign bus.ip2bus_mst_lock        = 1'b0;
  assign bus.ip2bus_mst_reset       = 1'b0;
  assign bus.ip2bus_mstrd_dst_rdy_n = ~(state_r == RD_DATA);
  assign bus.ip2bus_mstrd_dst_dsc_n = 1'b1;
  assign bus.ip2bus_mstwr_d         = buf_dout_s;
  assign bus.ip2bus_mstwr_src_rdy_n = ~wr_valid_s;
  assign bus.ip2bus_mstwr_sof_n     = ~(wr_valid_s & (wr_beat_r == {BW{1'b0}}));
  assign bus.ip2bus_mstwr_eof_n     = ~(wr_valid_s & (wr_beat_r == LAST_C));
  assign bus.ip2bus_mstwr_src_dsc_n = 1'b1;
  assign bus.ip2bus_mstwr_rem       = {(DATA_W/8){1'b0}};

endmodule

// File: tb/tb_ddr_burst_copy_engine.sv
// Bench for ddr_burst_copy_engine: table of copy jobs against a zero-wait IPIF model, plus hand sequences.
module tb_ddr_burst_copy_engine;
  localparam int DW    = 64;
  localparam int BEATS = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] rd_base = 32'd0;
  logic [31:0] wr_base = 32'd0;
  logic [15:0] num_bursts = 16'd0;
  logic        busy, op_done, op_error;
  logic [31:0] cycle_count;
  int total = 0;
  int bad   = 0;

  ddr_burst_copy_engine_if #(.DATA_W(DW)) bus ();

  ddr_burst_copy_engine #(.DATA_W(DW), .BURST_BEATS(BEATS), .CNT_W(16), .ADDR_STRIDE(0)) dut (
    .clock(clock), .reset(reset), .start(start), .rd_base(rd_base), .wr_base(wr_base),
    .num_bursts(num_bursts), .busy(busy), .op_done(op_done), .op_error(op_error),
    .cycle_count(cycle_count), .bus(bus)
  );

  always #5 clock = ~clock;

  typedef struct { logic is_wr; logic [31:0] addr; } cmd_t;
  typedef struct {
    logic [31:0] rd; logic [31:0] wr; logic [15:0] num; int err_burst;
    logic stall; logic poke; logic exp_err; int exp_cmds;
  } vec_t;

  cmd_t cmd_log[$];
  int   err_burst = -1;
  logic stall_en  = 1'b0;
  int   m_mode = 0, m_beat = 0, m_rd_idx = 0;
  logic [31:0] m_src = 32'd0;
  logic [63:0] m_held = 64'd0;
  logic        m_held_v = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a, input int b);
    logic [31:0] x;
    x = a + 32'(b) * 32'd8;
    return {x ^ 32'h5A5A_0000, ~x};
  endfunction

  task automatic bus_idle();
    bus.bus2ip_mst_cmdack      = 1'b0;
    bus.bus2ip_mst_cmplt       = 1'b0;
    bus.bus2ip_mst_error       = 1'b0;
    bus.bus2ip_mstrd_d         = 64'd0;
    bus.bus2ip_mstrd_src_rdy_n = 1'b1;
    bus.bus2ip_mstwr_dst_rdy_n = 1'b1;
  endtask

  // IPIF model: acts on the falling edge, DUT samples on the rising edge
  initial begin
    bus_idle();
    forever begin
      @(negedge clock);
      bus_idle();
      if (!reset) begin
        m_mode = 0; m_held_v = 1'b0;
      end else if (m_mode == 0) begin
        if (bus.ip2bus_mstrd_req) begin
          bus.bus2ip_mst_cmdack = 1'b1;
          cmd_log.push_back('{1'b0, bus.ip2bus_mst_addr});
          m_src = bus.ip2bus_mst_addr; m_beat = 0; m_mode = 1;
        end else if (bus.ip2bus_mstwr_req) begin
          bus.bus2ip_mst_cmdack = 1'b1;
          cmd_log.push_back('{1'b1, bus.ip2bus_mst_addr});
          m_beat = 0; m_held_v = 1'b0; m_mode = 2;
        end
      end else if (m_mode == 1) begin
        if (m_beat < BEATS) begin
          if (!bus.ip2bus_mstrd_dst_rdy_n) begin
            bus.bus2ip_mstrd_src_rdy_n = 1'b0;
            bus.bus2ip_mstrd_d = pat(m_src, m_beat);
            m_beat++;
          end
        end else begin
          bus.bus2ip_mst_cmplt = 1'b1;
          bus.bus2ip_mst_error = (m_rd_idx == err_burst);
          m_rd_idx++; m_mode = 0;
        end
      end else begin
        if (m_beat < BEATS) begin
          if (!bus.ip2bus_mstwr_src_rdy_n) begin
            if (m_held_v) check("wr_hold", bus.ip2bus_mstwr_d, m_held);
            bus.bus2ip_mstwr_dst_rdy_n = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
            if (!bus.bus2ip_mstwr_dst_rdy_n) begin
              check("wr_data", bus.ip2bus_mstwr_d, pat(m_src, m_beat));
              check("wr_sof_n", bus.ip2bus_mstwr_sof_n, (m_beat == 0) ? 1'b0 : 1'b1);
              check("wr_eof_n", bus.ip2bus_mstwr_eof_n, (m_beat == BEATS - 1) ? 1'b0 : 1'b1);
              m_beat++; m_held_v = 1'b0;
            end else begin
              m_held = bus.ip2bus_mstwr_d; m_held_v = 1'b1;
            end
          end
        end else begin
          bus.bus2ip_mst_cmplt = 1'b1;
          m_mode = 0;
        end
      end
    end
  end

  task automatic run_copy(input vec_t v);
    int busy_cycles, guard, pulses, k;
    logic exp_wr;
    logic [31:0] exp_addr;
    cmd_log.delete(); m_rd_idx = 0; err_burst = v.err_burst; stall_en = v.stall;
    @(negedge clock);
    rd_base = v.rd; wr_base = v.wr; num_bursts = v.num; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_on", busy, 1'b1);
    check("err_clr", op_error, 1'b0);
    busy_cycles = 1; guard = 0;
    while (!op_done && guard < 3000) begin
      if (v.poke && guard == 4) begin
        start = 1'b1; rd_base = 32'hDEAD_0000; num_bursts = 16'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      guard++;
      if (busy) busy_cycles++;
    end
    start = 1'b0;
    check("done_seen", op_done, 1'b1);
    check("done_busy", busy, 1'b0);
    pulses = 1;
    repeat (3) begin
      @(negedge clock);
      if (op_done) pulses++;
    end
    check("done_once", 64'(pulses), 64'd1);
    check("op_error", op_error, v.exp_err);
    check("cmd_count", 64'(cmd_log.size()), 64'(v.exp_cmds));
    for (int i = 0; i < cmd_log.size() && i < v.exp_cmds; i++) begin
      exp_wr   = 1'(i % 2);
      k        = i / 2;
      exp_addr = (exp_wr ? v.wr : v.rd) + 32'(k) * 32'd128;
      check("cmd_kind", cmd_log[i].is_wr, exp_wr);
      check("cmd_addr", cmd_log[i].addr, exp_addr);
    end
`ifdef DDR_COPY_PERF_CNT_EN
    check("cycle_count", cycle_count, 32'(busy_cycles));
`else
    check("cycle_count", cycle_count, 32'd0);
`endif
  endtask

  vec_t vecs[7];

  initial begin
    int guard;
    vecs[0] = '{32'h0000_1000, 32'h0000_8000, 16'd1, -1, 1'b0, 1'b0, 1'b0, 2};
    vecs[1] = '{32'h0000_1000, 32'h0000_8000, 16'd3, -1, 1'b0, 1'b0, 1'b0, 6};
    vecs[2] = '{32'h0000_2000, 32'h0000_9000, 16'd2, -1, 1'b1, 1'b1, 1'b0, 4};
    vecs[3] = '{32'h0000_1000, 32'h0000_8000, 16'd3,  1, 1'b0, 1'b0, 1'b1, 3};
    vecs[4] = '{32'h0000_1000, 32'h0000_8000, 16'd1, -1, 1'b1, 1'b0, 1'b0, 2};
    vecs[5] = '{32'hFFFF_FF00, 32'hFFFF_FF80, 16'd3, -1, 1'b1, 1'b0, 1'b0, 6};
    vecs[6] = '{32'h0000_3000, 32'h0000_7000, 16'd0, -1, 1'b0, 1'b0, 1'b0, 0};

    repeat (2) @(negedge clock);
    check("rst_busy", busy, 1'b0);
    check("rst_done", op_done, 1'b0);
    check("rst_err", op_error, 1'b0);
    check("rst_rdreq", bus.ip2bus_mstrd_req, 1'b0);
    check("rst_wrreq", bus.ip2bus_mstwr_req, 1'b0);
    check("rst_addr", bus.ip2bus_mst_addr, 32'd0);
    check("rst_rd_dst_n", bus.ip2bus_mstrd_dst_rdy_n, 1'b1);
    check("rst_wr_src_n", bus.ip2bus_mstwr_src_rdy_n, 1'b1);
    check("rst_sof_n", bus.ip2bus_mstwr_sof_n, 1'b1);
    check("rst_eof_n", bus.ip2bus_mstwr_eof_n, 1'b1);
    check("rst_cycles", cycle_count, 32'd0);
    check("length", bus.ip2bus_mst_length, 20'd128);
    check("be", bus.ip2bus_mst_be, 8'hFF);
    check("type", bus.ip2bus_mst_type, 1'b1);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_copy(vecs[i]);

    // Zero-length job: done pulse two cycles after the start pulse, no command
    cmd_log.delete();
    @(negedge clock);
    num_bursts = 16'd0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("n0_busy", busy, 1'b1);
    check("n0_early", op_done, 1'b0);
    @(negedge clock);
    check("n0_done", op_done, 1'b1);
    check("n0_busy_off", busy, 1'b0);
    @(negedge clock);
    check("n0_done_clr", op_done, 1'b0);
    check("n0_noreq", 64'(cmd_log.size()), 64'd0);

    // Reset in the middle of a write burst, then a clean copy
    cmd_log.delete(); m_rd_idx = 0; err_burst = -1; stall_en = 1'b1;
    @(negedge clock);
    rd_base = 32'h0000_4000; wr_base = 32'h0000_C000; num_bursts = 16'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    guard = 0;
    while (bus.ip2bus_mstwr_src_rdy_n && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    check("reach_wr_data", bus.ip2bus_mstwr_src_rdy_n, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wrreq", bus.ip2bus_mstwr_req, 1'b0);
    check("mid_rst_src_n", bus.ip2bus_mstwr_src_rdy_n, 1'b1);
    check("mid_rst_cycles", cycle_count, 32'd0);
    reset = 1'b1;
    run_copy(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
